pipe_ctrl: RTL

//   Parametrised pipeline stall/flush controller for the NSTAGE-deep core; successor to the fixed 5-stage CTRL.

---
 rtl/pipe_ctrl_if.sv | 37 +++
 rtl/pipe_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_if.sv
// Purpose : bundle of the stall/flush controller's pipeline-facing signals.
// Latency : none; this is wiring only.
// Backpressure: none; the stall bus is the backpressure the controller produces.
// Ports   : master = pipeline side (drives requests, receives stall/flush/PC/perf),
//           slave  = pipe_ctrl side.
interface pipe_ctrl_if #(
    parameter int NSTAGE = 5,
    parameter int MC_W   = 6,
    parameter int CNT_W  = 32
);
    logic [NSTAGE-1:0] stallreq;
    logic              mc_start;
    logic [MC_W-1:0]   mc_cycles;
    logic              flush_req;
    logic [31:0]       flush_pc;
    logic [NSTAGE:0]   stall;
    logic [NSTAGE-1:0] flush;
    logic              pc_we;
    logic [31:0]       pc_new;
    logic              mc_busy;
    logic              wdog_err;
    logic [CNT_W-1:0]  cyc_cnt;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output stallreq, mc_start, mc_cycles, flush_req, flush_pc,
        input  stall, flush, pc_we, pc_new, mc_busy, wdog_err,
               cyc_cnt, stall_cnt, flush_cnt
    );

    modport slave (
        input  stallreq, mc_start, mc_cycles, flush_req, flush_pc,
        output stall, flush, pc_we, pc_new, mc_busy, wdog_err,
               cyc_cnt, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Purpose : merges per-stage stall requests and the multi-cycle busy counter
//           into the stall bus, turns a redirect into flushes + PC load, and
//           watches for stuck stalls.
// Latency : stall/flush/pc_we/pc_new/mc_busy are combinational (0 cycles);
//           wdog_err and perf counters are registered (1 cycle).
// Backpressure: the controller itself is never stalled; it generates the stall bus.
// Ports   : clk, rst (async active-low), bus (pipe_ctrl_if.slave).
// Config  : define PERF_CNT_EN to build cyc_cnt/stall_cnt/flush_cnt; otherwise tied to 0.
module pipe_ctrl #(
    parameter int NSTAGE      = 5,
    parameter int MC_STAGE    = 2,
    parameter int FLUSH_STAGE = 3,
    parameter int MC_W        = 6,
    parameter int WDOG_CYC    = 1024,
    parameter int CNT_W       = 32
) (
    input  logic         clk,
    input  logic         rst,
    pipe_ctrl_if.slave   bus
);
    // A redirect at or behind the multi-cycle unit kills the op in flight.
    localparam bit       MC_KILLED = (MC_STAGE <= FLUSH_STAGE);
    localparam int       WD_W      = (WDOG_CYC > 2) ? $clog2(WDOG_CYC) : 1;
    localparam [WD_W-1:0] WD_MAX   = WD_W'(WDOG_CYC - 1);

    logic [MC_W-1:0]   mc_cnt_q, mc_cnt_d;
    logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
    logic              wdog_q, wdog_d;

    logic              mc_start_ok;
    logic              mc_kill;
    logic              mc_busy_c;
    logic [NSTAGE-1:0] req_c;
    logic [NSTAGE:0]   stall_c;
    logic [NSTAGE-1:0] flush_c;
    logic              any_req;

    // ---------------- multi-cycle counter ----------------
    always_comb begin
        mc_start_ok = bus.mc_start && (bus.mc_cycles != '0);
        mc_kill     = bus.flush_req && MC_KILLED;
        mc_busy_c   = ((mc_cnt_q != '0) || mc_start_ok) && !mc_kill;

        mc_cnt_d = mc_cnt_q;
        if (mc_kill) begin
            mc_cnt_d = '0;
        end else if (mc_cnt_q != '0) begin
            // Keeps counting down while stalled; a new start is ignored.
            mc_cnt_d = mc_cnt_q - MC_W'(1);
        end else if (mc_start_ok) begin
            // The start cycle itself is the first busy cycle.
            mc_cnt_d = bus.mc_cycles - MC_W'(1);
        end
    end

    // ---------------- stall / flush ----------------
    always_comb begin
        req_c = bus.stallreq;
        if (mc_busy_c) begin
            req_c[MC_STAGE] = 1'b1;
        end

        // stall[i+1] = OR of requests from stage i upward; stall[0] follows stall[1].
        stall_c = '0;
        any_req = 1'b0;
        for (int i = NSTAGE - 1; i >= 0; i--) begin
            any_req      = any_req | req_c[i];
            stall_c[i+1] = any_req;
        end
        stall_c[0] = any_req;

        flush_c = '0;
        for (int i = 0; i < NSTAGE; i++) begin
            flush_c[i] = bus.flush_req && (i <= FLUSH_STAGE);
        end

        // A redirect squashes everything younger, so holding it would be pointless.
        if (bus.flush_req) begin
            stall_c = '0;
        end
    end

    // Combinational outputs are forced low while reset is asserted.
    assign bus.stall   = rst ? stall_c : '0;
    assign bus.flush   = rst ? flush_c : '0;
    assign bus.pc_we   = rst & bus.flush_req;
    assign bus.pc_new  = (rst && bus.flush_req) ? bus.flush_pc : 32'h0;
    assign bus.mc_busy = rst & mc_busy_c;

    // ---------------- watchdog ----------------
    always_comb begin
        wd_cnt_d = '0;
        wdog_d   = wdog_q;
        if (bus.stall[0]) begin
            wd_cnt_d = (wd_cnt_q == WD_MAX) ? wd_cnt_q : wd_cnt_q + WD_W'(1);
            if (wd_cnt_q == WD_MAX) begin
                wdog_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mc_cnt_q <= '0;
            wd_cnt_q <= '0;
            wdog_q   <= 1'b0;
        end else begin
            mc_cnt_q <= mc_cnt_d;
            wd_cnt_q <= wd_cnt_d;
            wdog_q   <= wdog_d;
        end
    end

    assign bus.wdog_err = wdog_q;

    // ---------------- performance counters ----------------
`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] cyc_cnt_q, stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_cnt_q   <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            cyc_cnt_q <= cyc_cnt_q + CNT_W'(1);
            if (bus.stall[0]) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (bus.flush_req) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.cyc_cnt   = cyc_cnt_q;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
`else
    assign bus.cyc_cnt   = '0;
    assign bus.stall_cnt = '0;
    assign bus.flush_cnt = '0;
`endif

endmodule
